// File: rtl/sbox_share_ctrl.sv
// Time-shares one external 4-byte combinational S-box between a 128-bit state
// SubBytes request (four passes) and a 32-bit key-schedule SubWord request (one pass).
module sbox_share_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         st_valid,
    input  logic [127:0] st_data,
    output logic         st_ready,
    output logic         st_done,
    output logic [127:0] st_res,
    input  logic         ks_valid,
    input  logic [31:0]  ks_word,
    output logic         ks_ready,
    output logic         ks_done,
    output logic [31:0]  ks_res,
    output logic [31:0]  sbox_in,
    input  logic [31:0]  sbox_out,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, ST_RUN = 2'd1, KS_RUN = 2'd2} state_t;

    state_t          state_reg, state_next;
    logic [1:0]      cnt_reg, cnt_next;
    logic            last_ks_reg, last_ks_next;   // 1: key schedule won the last grant
    logic [127:0]    st_cap_reg;
    logic [31:0]     ks_cap_reg;
    logic [2:0][31:0] shadow_reg;
    logic [127:0]    st_res_reg;
    logic [31:0]     ks_res_reg;
    logic            st_done_reg, ks_done_reg;
    logic            grant_st, grant_ks;
    logic            st_fin, ks_fin, shadow_we;
    logic [31:0]     st_word [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_word
            assign st_word[gi] = st_cap_reg[127 - 32*gi -: 32];
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        last_ks_next = last_ks_reg;
        st_ready     = 1'b0;
        ks_ready     = 1'b0;
        st_fin       = 1'b0;
        ks_fin       = 1'b0;
        shadow_we    = 1'b0;
        sbox_in      = 32'h0;
        grant_st     = st_valid & (~ks_valid | last_ks_reg);
        grant_ks     = ks_valid & (~st_valid | ~last_ks_reg);

        case (state_reg)
            ST_RUN:  sbox_in = st_word[cnt_reg];
            KS_RUN:  sbox_in = ks_cap_reg;
            default: sbox_in = 32'h0;
        endcase

        if (clr) begin
            state_next = IDLE;
            cnt_next   = 2'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_st) begin
                        st_ready     = 1'b1;
                        state_next   = ST_RUN;
                        cnt_next     = 2'd0;
                        last_ks_next = 1'b0;
                    end else if (grant_ks) begin
                        ks_ready     = 1'b1;
                        state_next   = KS_RUN;
                        last_ks_next = 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt_next = cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3) begin
                        st_fin     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        shadow_we = 1'b1;
                    end
                end
                KS_RUN: begin
                    ks_fin     = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Words 0..2 collect in the shadow; st_res only changes once all four exist.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= 2'd0;
            last_ks_reg <= 1'b0;
            st_cap_reg  <= '0;
            ks_cap_reg  <= '0;
            shadow_reg  <= '0;
            st_res_reg  <= '0;
            ks_res_reg  <= '0;
            st_done_reg <= 1'b0;
            ks_done_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            last_ks_reg <= last_ks_next;
            st_done_reg <= st_fin;
            ks_done_reg <= ks_fin;
            if (st_ready)
                st_cap_reg <= st_data;
            if (ks_ready)
                ks_cap_reg <= ks_word;
            for (int i = 0; i < 3; i++) begin
                if (shadow_we && cnt_reg == 2'(i))
                    shadow_reg[i] <= sbox_out;
            end
            if (st_fin)
                st_res_reg <= {shadow_reg[0], shadow_reg[1], shadow_reg[2], sbox_out};
            if (ks_fin)
                ks_res_reg <= sbox_out;
        end
    end

    assign st_res  = st_res_reg;
    assign ks_res  = ks_res_reg;
    assign st_done = st_done_reg;
    assign ks_done = ks_done_reg;
    assign busy    = (state_reg != IDLE);

endmodule

// File: doc/sbox_share_ctrl.md
SBOX_SHARE_CTRL -- requirements
Module: sbox_share_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port clr, input, 1, synchronous abort to IDLE.
REQ-004 SHALL have port st_valid, input, 1, state-SubBytes request.
REQ-005 SHALL have port st_data, input, 128, state to substitute; bits [127:96] = word 0.
REQ-006 SHALL have port st_ready, output, 1, st request accepted this cycle.
REQ-007 SHALL have port st_done, output, 1, one-cycle pulse, st_res updated.
REQ-008 SHALL have port st_res, output, 128, substituted state.
REQ-009 SHALL have port ks_valid, input, 1, key-schedule SubWord request.
REQ-010 SHALL have port ks_word, input, 32, word to substitute.
REQ-011 SHALL have port ks_ready, output, 1, ks request accepted this cycle.
REQ-012 SHALL have port ks_done, output, 1, one-cycle pulse, ks_res updated.
REQ-013 SHALL have port ks_res, output, 32, substituted word.
REQ-014 SHALL have port sbox_in, output, 32, operand to shared 4-byte combinational S-box.
REQ-015 SHALL have port sbox_out, input, 32, S-box result, same cycle as sbox_in.
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ST_RUN, KS_RUN; only IDLE accepts requests.
REQ-018 SHALL drive st_ready = IDLE & st_valid & grant_st, and ks_ready = IDLE & ks_valid & grant_ks, combinationally.
REQ-019 SHALL arbitrate round-robin on a last_grant flag: single requester wins; when both valid, the one not last granted wins; last_grant updates on each accept.
REQ-020 SHALL, on st accept, capture st_data, clear 2-bit word counter, enter ST_RUN.
REQ-021 SHALL in ST_RUN drive sbox_in = captured word[cnt] (cnt 0 = bits [127:96]) and write sbox_out into st_res word[cnt] at the edge; cnt increments; after cnt==3 go to IDLE.
REQ-022 SHALL, on ks accept, capture ks_word, enter KS_RUN; in KS_RUN drive sbox_in = captured word, load ks_res from sbox_out, return to IDLE.
REQ-023 SHALL assert st_done for exactly one cycle, the cycle after the cnt==3 edge (4 edges after accept); ks_done one cycle, 1 edge after accept.
REQ-024 SHALL allow a new accept in the same cycle as a done pulse (IDLE); st throughput 1 request / 5 cycles, ks 1 / 2 cycles.
REQ-025 SHALL hold st_res and ks_res stable between their own updates; a partial st_res is never exposed (write into shadow, copy to st_res at final word).
REQ-026 SHALL drive sbox_in = 32'h0 in IDLE.
REQ-027 SHALL on clr=1 go to IDLE, zero cnt, suppress done pulses and ready; results keep last completed values; clr overrides valid same cycle.
REQ-028 SHALL ignore input data changes after accept (captured copy used).

Reset
REQ-029 SHALL on rst_n=0 asynchronously force IDLE, cnt=0, last_grant=ST (so ks wins first tie), st_res=0, ks_res=0, st_done=ks_done=0, busy=0, sbox_in=0.
REQ-030 SHALL discard any in-flight operation on reset mid-run with no done pulse after release.

Verification
REQ-031 SHALL check: st_data=128'h19a09ae93df4c6f8e3e28d48be2b2a08 -> st_done 4 edges after accept, st_res=128'hd4e0b81e27bfb44111985d52aef1e530.
REQ-032 SHALL check: ks_word=32'hcf4f3c09 -> ks_done 1 edge after accept, ks_res=32'h8a84eb01.
REQ-033 SHALL check: st_valid and ks_valid both high from reset -> ks granted first, st granted in the cycle ks_done pulses, then alternation on continued contention.
REQ-034 SHALL check: clr asserted at cnt==2 -> IDLE next cycle, no st_done, st_res unchanged from prior value.
REQ-035 SHALL check: rst_n low mid ST_RUN -> all outputs zero immediately (asynchronous), no done after release.
REQ-036 SHALL check: back-to-back st requests -> accepts 5 cycles apart, st_res never shows partial mix of old and new words.
